// File: rtl/piso_shifter.sv
// -----------------------------------------------------------------------------
// piso_shifter -- parallel-in / serial-out frame shifter, LSB first.
//
// A word is captured on a load request while idle and shifted out one bit per
// enabled clock. Each bit stays on oSer until the edge that shifts it out. The
// active-low iEnb input can stall the shifter for any number of cycles. A
// one-cycle oDone pulse follows the last bit, then the block returns to idle.
//
// Optional feature (macro PISO_PARITY_EN):
//   When defined, the even parity of the loaded word (XOR of iD) is appended
//   as one extra frame bit after the WIDTH data bits. When undefined, frames
//   are exactly WIDTH bits and no parity logic exists.
//
// Parameters:
//   WIDTH   parallel word width, 2..32
//
// Ports:
//   iClk    clock, rising edge
//   iClr    asynchronous reset, active high
//   iD      parallel word to serialize
//   iLoad   load request, only honoured while oReady=1
//   iEnb    shift enable, active low (1 = stall)
//   oSer    registered serial data, LSB first, 0 outside a frame
//   oReady  high while a new word can be accepted
//   oBusy   high while a frame is being shifted
//   oDone   one-cycle pulse after the last frame bit
// -----------------------------------------------------------------------------
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic [WIDTH-1:0] iD,
  input  logic             iLoad,
  input  logic             iEnb,
  output logic             oSer,
  output logic             oReady,
  output logic             oBusy,
  output logic             oDone
);

  // Frame length and shift register width; the parity bit rides in the MSB
  // so it falls into bit 0 right after the last data bit.
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int SW = FRAME;
  // Sized for WIDTH+1 so the counter never wraps, even with parity enabled.
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [SW-1:0] r_sreg;
  logic [CW-1:0] r_cnt;
  logic          r_ser;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [SW-1:0] w_sreg_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] w_load_val;
  logic          w_last;

`ifdef PISO_PARITY_EN
  assign w_load_val = {^iD, iD};
`else
  assign w_load_val = iD;
`endif

  assign w_last = (r_cnt == CW'(FRAME - 1));

  // Next-state logic. iLoad is only looked at in IDLE, so requests arriving
  // during SHIFT or DONE are dropped rather than queued.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (iLoad) begin
          w_sreg_nxt  = w_load_val;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!iEnb) begin
          w_sreg_nxt = r_sreg >> 1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        // Unused encoding recovers to IDLE.
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe and come straight out of flops.
  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_ser   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ser   <= (w_state_nxt == S_SHIFT) ? w_sreg_nxt[0] : 1'b0;
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign oSer   = r_ser;
  assign oReady = r_ready;
  assign oBusy  = r_busy;
  assign oDone  = r_done;

endmodule

// File: tb/tb_piso_shifter.sv
module tb_piso_shifter;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] d   = '0;
  logic             load = 1'b0;
  logic             enb  = 1'b0;
  logic             ser, ready, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  piso_shifter #(.WIDTH(WIDTH)) dut (
    .iClk   (clk),
    .iClr   (clr),
    .iD     (d),
    .iLoad  (load),
    .iEnb   (enb),
    .oSer   (ser),
    .oReady (ready),
    .oBusy  (busy),
    .oDone  (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status triple packed as {ready, busy, done}.
  function automatic logic [31:0] st();
    return {29'd0, ready, busy, done};
  endfunction

  task automatic load_word(input logic [WIDTH-1:0] w);
    d    = w;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Checks one complete frame starting in the first SHIFT cycle.
  // par: hand-computed parity bit; stall_at/stall_n: hold iEnb high for
  // stall_n cycles while bit stall_at is shown; busy_load: drive iLoad=1 with
  // iD=FF through SHIFT and DONE.
  task automatic run_frame(input string nm, input logic [WIDTH-1:0] w, input logic par,
                           input int stall_at, input int stall_n, input logic busy_load);
    logic exp_bit;
    if (busy_load) begin
      d    = '1;
      load = 1'b1;
    end
    for (int i = 0; i < FRAME; i++) begin
      exp_bit = (i < WIDTH) ? w[i] : par;
      chk($sformatf("%s bit%0d ser", nm, i), {31'd0, ser}, {31'd0, exp_bit});
      chk($sformatf("%s bit%0d rbd", nm, i), st(), 32'b010);
      if (i == stall_at) begin
        enb = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk($sformatf("%s stall%0d ser", nm, s), {31'd0, ser}, {31'd0, exp_bit});
          chk($sformatf("%s stall%0d rbd", nm, s), st(), 32'b010);
        end
        enb = 1'b0;
      end
      tick();
    end
    chk({nm, " done rbd"}, st(), 32'b001);
    chk({nm, " done ser"}, {31'd0, ser}, 32'd0);
    tick();
    load = 1'b0;
    chk({nm, " idle rbd"}, st(), 32'b100);
    chk({nm, " idle ser"}, {31'd0, ser}, 32'd0);
    tick();
    chk({nm, " no next frame"}, st(), 32'b100);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 clr = 1'b1;
    #1;
    chk("reset rbd", st(), 32'b100);
    chk("reset ser", {31'd0, ser}, 32'd0);
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("idle no load", st(), 32'b100);

    // Basic frame A5 -> 1,0,1,0,0,1,0,1 (parity 0).
    load_word(8'hA5);
    run_frame("A5", 8'hA5, 1'b0, -1, 0, 1'b0);

    // Stall after 2nd bit of 0F -> 1,1,(1,1,1),1,1,0,0,0,0 (parity 0).
    load_word(8'h0F);
    run_frame("0F", 8'h0F, 1'b0, 1, 3, 1'b0);

    // Load held during SHIFT/DONE of 01 -> only 1,0,0,0,0,0,0,0 (parity 1).
    load_word(8'h01);
    run_frame("01busy", 8'h01, 1'b1, -1, 0, 1'b1);

    // Reset mid-frame of C3 (bits 1,1,0,0,...) at the 4th bit.
    load_word(8'hC3);
    chk("C3 bit0", {31'd0, ser}, 32'd1);
    tick();
    chk("C3 bit1", {31'd0, ser}, 32'd1);
    tick();
    chk("C3 bit2", {31'd0, ser}, 32'd0);
    tick();
    chk("C3 bit3 rbd", st(), 32'b010);
    #1 clr = 1'b1;
    #1;
    chk("midclr rbd", st(), 32'b100);
    chk("midclr ser", {31'd0, ser}, 32'd0);
    #2 clr = 1'b0;
    tick();
    chk("after clr rbd", st(), 32'b100);
    tick();
    chk("after clr no done", st(), 32'b100);

    // Frame after reset: 81 -> 1,0,0,0,0,0,0,1 (parity 0).
    load_word(8'h81);
    run_frame("81", 8'h81, 1'b0, -1, 0, 1'b0);

    // 07 -> 1,1,1,0,0,0,0,0 (parity 1).
    load_word(8'h07);
    run_frame("07", 8'h07, 1'b1, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
